pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
//   NCH-channel PWM generator sharing one period counter; successor to the single-channel pwm.
//   Double-buffered period/duty registers, loaded only at period boundaries, so updates never glitch.
//   Sits between the PS-side AXI register bank and motor/LED driver pins; o_period_end can sync ADC/IRQ.
// PARAMETERS
//   NB   32  width of period counter, period and each duty value
//   NCH  4   number of PWM channels (>=1)
//   DTW  8   dead-time counter width (used only with PWM_DEADTIME_EN)
// PORTS
//   clk            in   1       system clock, all logic rising-edge
//   i_reset        in   1       synchronous, active-high reset
//   i_enable       in   1       run counter/outputs when 1
//   i_load         in   1       1-cycle strobe: request load of i_max_counter/i_max_duty into active regs
//   i_max_counter  in   NB      period in clk cycles (0 = channel outputs forced low)
//   i_max_duty     in   NCH*NB  duty per channel, channel k at [k*NB +: NB]
//   i_deadtime     in   DTW     dead band in cycles (PWM_DEADTIME_EN only)
//   o_pwm          out  NCH     PWM outputs (high side)
//   o_pwm_n        out  NCH     complementary outputs (PWM_DEADTIME_EN only)
//   o_period_end   out  1       1-cycle pulse when counter wraps
//   o_update_ack   out  1       1-cycle pulse when active regs are (re)loaded
// BEHAVIOUR
//   - Reset: cnt=0, active period/duty=0, pending=0, o_pwm=0, o_pwm_n=0, o_period_end=0, o_update_ack=0.
//   - i_load sets pending; i_max_counter/i_max_duty are sampled at the cycle of the load, not of i_load.
//     Caller holds inputs stable until o_update_ack.
//   - Load point: cnt==P_act-1 with i_enable=1 and P_act!=0 (period boundary), OR immediately if
//     i_enable=0 or P_act==0. At load: active<=inputs, pending<=0, o_update_ack=1 next cycle.
//   - i_load coincident with boundary: loaded at that boundary. Repeated i_load while pending: no effect
//     beyond keeping pending set (latest inputs win).
//   - Counter: if i_enable && P_act!=0: cnt <= (cnt==P_act-1) ? 0 : cnt+1; else cnt<=0.
//     Period = P_act cycles. o_period_end=1 the cycle after cnt==P_act-1.
//   - Raw compare r[k] = i_enable && P_act!=0 && (cnt < D_act[k]); registered: 1-cycle latency.
//     Exactly D_act[k] high cycles per period; D=0 -> constant low; D>=P -> constant high.
//   - All compares unsigned NB-bit; no overflow (cnt < P_act <= 2^NB-1).
//   - i_enable falling: next cycle cnt=0, all outputs 0, pending load applies immediately.
//     i_enable rising: counting starts from cnt=0; first o_pwm high one cycle later.
//   - Reset mid-operation overrides all: state returns to reset values next cycle.
// CONFIGURATION
//   PWM_DEADTIME_EN defined: adds i_deadtime, o_pwm_n; per channel a DTW-bit dead-time counter.
//     On r[k] rise: o_pwm_n[k]<=0 at once, o_pwm[k]<=1 after i_deadtime cycles of r stable high.
//     On r[k] fall: o_pwm[k]<=0 at once, o_pwm_n[k]<=1 after i_deadtime cycles of r stable low.
//     r pulse shorter than i_deadtime -> that output never asserts (both stay low). Never both high.
//     i_deadtime=0 -> o_pwm=r, o_pwm_n=~r while enabled; both 0 when disabled or P_act==0.
//     i_deadtime sampled live (not double-buffered).
//   PWM_DEADTIME_EN undefined: o_pwm=r registered, no i_deadtime/o_pwm_n ports, no dead-time logic.
// TESTING (NCH=2, NB=8, DTW=4)
//   1 reset, load P=10 D0=2 D1=5, enable -> o_pwm[0] 2/10 high, o_pwm[1] 5/10, o_period_end every 10.
//   2 mid-period load P=6 D0=3 -> current 10-cycle period completes, ack at wrap, then 3/6 on ch0.
//   3 D0=0, D1=15 with P=10 -> ch0 constant 0, ch1 constant 1; then P=0 -> all outputs 0, cnt held 0.
//   4 i_reset high mid-period -> next cycle all outputs 0; after release, no output until new load.
//   5 i_enable low at cnt=4 -> outputs 0 next cycle; re-enable -> period restarts at cnt=0, same duty.
//   6 PWM_DEADTIME_EN, DT=2, P=10 D=5 -> o_pwm 3 high, o_pwm_n 3 high, two 2-cycle gaps both low;
//     D=1 DT=2 -> o_pwm never high, o_pwm_n low 3 cycles per period; never both high.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, double-buffered period/duty updates at period boundaries.
// Optional complementary outputs with dead-time insertion when PWM_DEADTIME_EN is defined.
module pwm_multi #(
    parameter int unsigned NB  = 32,
    parameter int unsigned NCH = 4,
    parameter int unsigned DTW = 8
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [NB-1:0]     i_max_counter,
    input  logic [NCH*NB-1:0] i_max_duty,
`ifdef PWM_DEADTIME_EN
    input  logic [DTW-1:0]    i_deadtime,
    output logic [NCH-1:0]    o_pwm_n,
`endif
    output logic [NCH-1:0]    o_pwm,
    output logic              o_period_end,
    output logic              o_update_ack
);

    if (NCH < 1 || DTW < 1) begin : g_bad_params
        $error("pwm_multi: NCH and DTW must both be at least 1");
    end

    logic [NB-1:0]  cnt;
    logic [NB-1:0]  p_act;
    logic [NB-1:0]  d_act [NCH];
    logic           pending;

    logic           running;
    logic           at_end;
    logic           load_now;
    logic [NCH-1:0] raw;

    always_comb begin
        running  = i_enable && (p_act != '0);
        at_end   = running && (cnt == p_act - NB'(1));
        // A stopped or zero-period generator has no boundary to wait for, so loads apply at once.
        load_now = (i_load || pending) && (!i_enable || (p_act == '0) || at_end);
        raw      = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            raw[k] = running && (cnt < d_act[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt          <= '0;
            p_act        <= '0;
            pending      <= 1'b0;
            o_period_end <= 1'b0;
            o_update_ack <= 1'b0;
            for (int unsigned k = 0; k < NCH; k++) begin
                d_act[k] <= '0;
            end
`ifndef PWM_DEADTIME_EN
            o_pwm        <= '0;
`endif
        end else begin
            if (running && !at_end) begin
                cnt <= cnt + NB'(1);
            end else begin
                cnt <= '0;
            end
            o_period_end <= at_end;
            o_update_ack <= load_now;
            if (load_now) begin
                p_act   <= i_max_counter;
                pending <= 1'b0;
                for (int unsigned k = 0; k < NCH; k++) begin
                    d_act[k] <= i_max_duty[k*NB +: NB];
                end
            end else if (i_load) begin
                pending <= 1'b1;
            end
`ifndef PWM_DEADTIME_EN
            o_pwm        <= raw;
`endif
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [NCH-1:0] raw_q;
    logic [DTW-1:0] run_len [NCH];
    logic [NCH-1:0] settled;

    // run_len counts completed cycles that raw has held its previous level (saturating).
    always_comb begin
        settled = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            settled[k] = ((raw[k] == raw_q[k]) ? run_len[k] : '0) >= i_deadtime;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            raw_q   <= '0;
            o_pwm   <= '0;
            o_pwm_n <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                run_len[k] <= '0;
            end
        end else begin
            raw_q <= raw;
            for (int unsigned k = 0; k < NCH; k++) begin
                if (raw[k] != raw_q[k]) begin
                    run_len[k] <= DTW'(1);
                end else if (run_len[k] != '1) begin
                    run_len[k] <= run_len[k] + DTW'(1);
                end
                o_pwm[k]   <= raw[k] && settled[k];
                o_pwm_n[k] <= running && !raw[k] && settled[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (NCH=2, NB=8, DTW=4): directed scenarios plus randomized traffic against a reference model.
module tb_pwm_multi;

    localparam int unsigned NB  = 8;
    localparam int unsigned NCH = 2;
    localparam int unsigned DTW = 4;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic              i_load;
    logic [NB-1:0]     i_max_counter;
    logic [NCH*NB-1:0] i_max_duty;
    logic [NCH-1:0]    o_pwm;
    logic              o_period_end;
    logic              o_update_ack;
`ifdef PWM_DEADTIME_EN
    logic [DTW-1:0]    i_deadtime;
    logic [NCH-1:0]    o_pwm_n;
`endif

    always #5 clk = ~clk;

    pwm_multi #(.NB(NB), .NCH(NCH), .DTW(DTW)) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_load        (i_load),
        .i_max_counter (i_max_counter),
        .i_max_duty    (i_max_duty),
`ifdef PWM_DEADTIME_EN
        .i_deadtime    (i_deadtime),
        .o_pwm_n       (o_pwm_n),
`endif
        .o_pwm         (o_pwm),
        .o_period_end  (o_period_end),
        .o_update_ack  (o_update_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: position within the period, active settings and pending flag as plain integers.
    int             m_cnt;
    int             m_p;
    int             m_d [NCH];
    bit             m_pend;
    logic [NCH-1:0] e_pwm;
    logic           e_pe;
    logic           e_ack;
`ifdef PWM_DEADTIME_EN
    logic [NCH-1:0] e_pwm_n;
    int             hist [NCH][$];   // per-cycle raw level history, 2 marks a reset cycle
`endif

    function automatic void model_step();
        bit             run;
        bit             wrap;
        bit             ld;
        logic [NCH-1:0] r;
        int             prior;
        if (i_reset) begin
            m_cnt  = 0;
            m_p    = 0;
            m_pend = 0;
            for (int k = 0; k < NCH; k++) m_d[k] = 0;
            e_pwm = '0;
            e_pe  = 1'b0;
            e_ack = 1'b0;
`ifdef PWM_DEADTIME_EN
            e_pwm_n = '0;
            for (int k = 0; k < NCH; k++) hist[k].push_back(2);
`endif
            return;
        end
        run  = i_enable && (m_p != 0);
        wrap = run && (m_cnt == m_p - 1);
        for (int k = 0; k < NCH; k++) r[k] = run && (m_cnt < m_d[k]);
        e_pe = wrap;
`ifdef PWM_DEADTIME_EN
        for (int k = 0; k < NCH; k++) begin
            prior = 0;
            for (int j = hist[k].size() - 1; j >= 0 && prior < 15; j--) begin
                if (hist[k][j] != int'(r[k])) break;
                prior++;
            end
            e_pwm[k]   = r[k] && (prior >= int'(i_deadtime));
            e_pwm_n[k] = run && !r[k] && (prior >= int'(i_deadtime));
            hist[k].push_back(int'(r[k]));
            if (hist[k].size() > 16) void'(hist[k].pop_front());
        end
`else
        prior = 0;
        e_pwm = r;
`endif
        m_cnt = (run && !wrap) ? m_cnt + 1 : 0;
        ld    = (i_load || m_pend) && (!i_enable || (m_p == 0) || wrap);
        e_ack = ld;
        if (ld) begin
            m_p = int'(i_max_counter);
            for (int k = 0; k < NCH; k++) m_d[k] = int'(i_max_duty[k*NB +: NB]);
            m_pend = 0;
        end else if (i_load) begin
            m_pend = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pwm", o_pwm, e_pwm);
        check("period_end", o_period_end, e_pe);
        check("update_ack", o_update_ack, e_ack);
`ifdef PWM_DEADTIME_EN
        check("pwm_n", o_pwm_n, e_pwm_n);
        check("no_overlap", o_pwm & o_pwm_n, 0);
`endif
    endtask

    task automatic set_cfg(input int p, input int d0, input int d1);
        i_max_counter = NB'(p);
        i_max_duty    = {NB'(d1), NB'(d0)};
    endtask

    task automatic do_load();
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
    endtask

    task automatic wait_ack(input int limit);
        int n = 0;
        while (!o_update_ack && n < limit) begin
            tick();
            n++;
        end
        check("ack_seen", o_update_ack, 1);
    endtask

    task automatic count_win(input int n, output int c0, output int c1, output int cpe);
        c0 = 0; c1 = 0; cpe = 0;
        repeat (n) begin
            tick();
            c0  += int'(o_pwm[0]);
            c1  += int'(o_pwm[1]);
            cpe += int'(o_period_end);
        end
    endtask

    initial begin
        int c0, c1, cpe, sel;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_load   = 1'b0;
        set_cfg(0, 0, 0);
`ifdef PWM_DEADTIME_EN
        i_deadtime = '0;
`endif
        tick();
        tick();
        check("rst_pwm", o_pwm, 0);
        check("rst_pe", o_period_end, 0);
        check("rst_ack", o_update_ack, 0);
        i_reset = 1'b0;

        // Basic 2/10 and 5/10 duty
        set_cfg(10, 2, 5);
        do_load();
        wait_ack(4);
        i_enable = 1'b1;
        count_win(20, c0, c1, cpe);
        check("s1_ch0_high", c0, 4);
        check("s1_ch1_high", c1, 10);
        check("s1_period_end", cpe, 2);

        // Mid-period update waits for the wrap
        repeat (3) tick();
        set_cfg(6, 3, 1);
        do_load();
        check("s2_no_early_ack", o_update_ack, 0);
        wait_ack(20);
        check("s2_ack_at_wrap", o_period_end, 1);
        count_win(12, c0, c1, cpe);
        check("s2_ch0_high", c0, 6);
        check("s2_ch1_high", c1, 2);
        check("s2_period_end", cpe, 2);

        // D=0 and D>P, then P=0
        set_cfg(10, 0, 15);
        do_load();
        wait_ack(20);
        count_win(10, c0, c1, cpe);
        check("s3_ch0_zero", c0, 0);
        check("s3_ch1_full", c1, 10);
        set_cfg(0, 3, 3);
        do_load();
        wait_ack(20);
        count_win(5, c0, c1, cpe);
        check("s3_p0_ch0", c0, 0);
        check("s3_p0_ch1", c1, 0);
        check("s3_p0_pe", cpe, 0);

        // Reset mid-period
        set_cfg(10, 5, 5);
        do_load();
        wait_ack(4);
        repeat (4) tick();
        i_reset = 1'b1;
        tick();
        check("s4_rst_pwm", o_pwm, 0);
        i_reset = 1'b0;
        count_win(10, c0, c1, cpe);
        check("s4_idle_ch0", c0, 0);
        check("s4_idle_pe", cpe, 0);

        // Enable drop and restart
        set_cfg(10, 4, 7);
        do_load();
        wait_ack(4);
        repeat (5) tick();
        i_enable = 1'b0;
        tick();
        check("s5_off_pwm", o_pwm, 0);
        repeat (2) tick();
        i_enable = 1'b1;
        count_win(10, c0, c1, cpe);
        check("s5_ch0_high", c0, 4);
        check("s5_ch1_high", c1, 7);
        check("s5_period_end", cpe, 1);

`ifdef PWM_DEADTIME_EN
        begin
            int p0, n0, both0, p1, n1;
            i_deadtime = DTW'(2);
            set_cfg(10, 5, 1);
            do_load();
            wait_ack(20);
            repeat (10) tick();
            p0 = 0; n0 = 0; both0 = 0; p1 = 0; n1 = 0;
            repeat (10) begin
                tick();
                p0    += int'(o_pwm[0]);
                n0    += int'(o_pwm_n[0]);
                both0 += int'(!o_pwm[0] && !o_pwm_n[0]);
                p1    += int'(o_pwm[1]);
                n1    += int'(o_pwm_n[1]);
            end
            check("s6_ch0_pwm", p0, 3);
            check("s6_ch0_pwm_n", n0, 3);
            check("s6_ch0_gap", both0, 4);
            check("s6_ch1_pwm", p1, 0);
            check("s6_ch1_pwm_n", n1, 7);
        end
`endif

        // Randomized traffic
        repeat (1500) begin
            i_load = 1'b0;
            sel = int'($urandom_range(0, 99));
            if (i_enable && sel < 2) i_enable = 1'b0;
            else if (!i_enable && sel < 20) i_enable = 1'b1;
            if (sel >= 90) begin
                i_max_counter = ($urandom_range(0, 9) == 0) ? '0 : NB'($urandom_range(1, 12));
                for (int k = 0; k < NCH; k++) i_max_duty[k*NB +: NB] = NB'($urandom_range(0, 14));
                i_load = 1'b1;
            end
            i_reset = ($urandom_range(0, 299) == 0);
`ifdef PWM_DEADTIME_EN
            if ($urandom_range(0, 49) == 0) i_deadtime = DTW'($urandom_range(0, 4));
`endif
            tick();
        end
        i_reset = 1'b0;
        i_load  = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
